// File: rtl/gear_pkg.sv
// Shared types and geometry helpers for the GeAr error-correction back end.
package gear_pkg;

    typedef enum logic [1:0] {GEAR_IDLE, GEAR_CORRECT, GEAR_DONE} gear_state_t;

    // Sub-adder window length.
    function automatic int unsigned gear_l(input int unsigned r, input int unsigned p);
        return r + p;
    endfunction

    // Number of sub-adders covering a width-bit operand.
    function automatic int unsigned gear_k(input int unsigned width, input int unsigned r,
                                           input int unsigned p);
        return (width - r - p) / r + 1;
    endfunction

endpackage

// File: rtl/gear_subadder.sv
// L-bit window adder; one instance per GeAr sub-adder.
module gear_subadder #(
    parameter int unsigned L = 8
) (
    input  logic [L-1:0] a,
    input  logic [L-1:0] b,
    input  logic         cin,
    output logic [L-1:0] s
);

    assign s = a + b + {{(L-1){1'b0}}, cin};

endmodule

// File: rtl/gear_err_corrector.sv
// GeAr approximate adder with sequential error detection and per-sub-adder correction.
// Optional saturating correction counter on err_cnt when GEAR_ECU_STATS_EN is defined.
module gear_err_corrector
    import gear_pkg::*;
#(
    parameter int unsigned R     = 4,
    parameter int unsigned P     = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             err_detected
`ifdef GEAR_ECU_STATS_EN
    ,
    output logic [15:0]      err_cnt
`endif
);

    localparam int unsigned L = gear_l(R, P);
    localparam int unsigned K = gear_k(WIDTH, R, P);
    localparam logic [WIDTH-1:0] PMask = {{(WIDTH-P){1'b0}}, {P{1'b1}}};

    if (WIDTH < L || ((WIDTH - L) % R) != 0) begin : g_bad_geometry
        $error("gear_err_corrector: WIDTH-R-P must be a non-negative multiple of R");
    end

    // Approximate sum from the K speculative sub-adders.
    logic [WIDTH-1:0] approx;

    for (genvar k = 0; k < K; k++) begin : g_sa
        logic [L-1:0] s;

        gear_subadder #(.L(L)) u_sa (
            .a   (a[R*k +: L]),
            .b   (b[R*k +: L]),
            .cin ((k == 0) ? carry_in : 1'b0),
            .s   (s)
        );

        if (k == 0) begin : g_first
            assign approx[L-1:0] = s;
        end else begin : g_rest
            logic unused_lo;
            assign approx[R*k+P +: R] = s[L-1:P];
            assign unused_lo = ^s[P-1:0];
        end
    end

    // SAk is wrong exactly when its P speculation bits all propagate and the true carry is 1.
    logic [K-1:0]   err_new;
    logic [WIDTH:0] lo_mask;
    logic [WIDTH:0] low_sum;

    always_comb begin
        err_new = '0;
        lo_mask = '0;
        low_sum = '0;
        for (int unsigned k = 1; k < K; k++) begin
            lo_mask = {(WIDTH+1){1'b1}} >> (WIDTH + 1 - R*k);
            low_sum = ({1'b0, a} & lo_mask) + ({1'b0, b} & lo_mask)
                    + {{WIDTH{1'b0}}, carry_in};
            err_new[k] = (&(((a ^ b) >> (R*k)) | ~PMask)) & low_sum[R*k];
        end
    end

    gear_state_t      state_q;
    logic [WIDTH-1:0] sum_q;
    logic [K-1:0]     err_q;
    logic             err_det_q;
    logic             in_ready_q;
    logic             out_valid_q;

    // Repair only the lowest flagged sub-adder this cycle.
    logic [WIDTH-1:0] fix_sum;
    logic [K-1:0]     fix_err;
    logic             fix_found;

    always_comb begin
        fix_sum   = sum_q;
        fix_err   = err_q;
        fix_found = 1'b0;
        for (int unsigned k = 1; k < K; k++) begin
            if (!fix_found && err_q[k]) begin
                fix_found              = 1'b1;
                fix_err[k]             = 1'b0;
                fix_sum[R*k+P +: R]    = sum_q[R*k+P +: R] + R'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= GEAR_IDLE;
            sum_q       <= '0;
            err_q       <= '0;
            err_det_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                GEAR_IDLE: begin
                    if (in_valid) begin
                        sum_q      <= approx;
                        err_q      <= err_new;
                        err_det_q  <= |err_new;
                        in_ready_q <= 1'b0;
                        if (|err_new) begin
                            state_q <= GEAR_CORRECT;
                        end else begin
                            state_q     <= GEAR_DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                GEAR_CORRECT: begin
                    sum_q <= fix_sum;
                    err_q <= fix_err;
                    if (fix_err == '0) begin
                        state_q     <= GEAR_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                GEAR_DONE: begin
                    if (out_ready) begin
                        state_q     <= GEAR_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= GEAR_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef GEAR_ECU_STATS_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (state_q == GEAR_CORRECT && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign sum          = sum_q;
    assign err_detected = err_det_q;

endmodule

// File: tb/tb_gear_err_corrector.sv
// Self-checking bench for gear_err_corrector (WIDTH=16, R=4, P=4); checks err_cnt
// as well when GEAR_ECU_STATS_EN is defined.
module tb_gear_err_corrector;

    localparam int unsigned R = 4;
    localparam int unsigned P = 4;
    localparam int unsigned W = 16;
    localparam int unsigned L = R + P;
    localparam int unsigned K = (W - L) / R + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          carry_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          err_detected;
`ifdef GEAR_ECU_STATS_EN
    logic [15:0]   err_cnt;
`endif

    gear_err_corrector #(.R(R), .P(P), .WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .carry_in     (carry_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .sum          (sum),
        .err_detected (err_detected)
`ifdef GEAR_ECU_STATS_EN
        ,
        .err_cnt      (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_pass  = 0;
    int unsigned model_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int unsigned model_sum(input int unsigned x, input int unsigned y,
                                              input int unsigned c);
        return (x + y + c) & 32'hFFFF;
    endfunction

    // Count sub-adders whose speculative upper R bits differ from the exact sum bits.
    function automatic int unsigned model_nerr(input int unsigned x, input int unsigned y,
                                               input int unsigned c);
        int unsigned n = 0;
        int unsigned exact = x + y + c;
        for (int unsigned k = 1; k < K; k++) begin
            int unsigned lo = R * k;
            int unsigned wa = (x >> lo) & ((1 << L) - 1);
            int unsigned wb = (y >> lo) & ((1 << L) - 1);
            int unsigned ap = ((wa + wb) >> P) & ((1 << R) - 1);
            int unsigned ex = (exact >> (lo + P)) & ((1 << R) - 1);
            if (ap != ex) n++;
        end
        return n;
    endfunction

    // One full transaction, starting and ending at a negedge with the DUT idle.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic ocin,
                          input int stall, input bit poke,
                          output logic [W-1:0] got_sum, output int got_lat,
                          output logic got_err);
        int          lat;
        int unsigned n;
        logic [W-1:0] held;
        n = model_nerr(oa, ob, ocin);
        check("in_ready_idle", in_ready, 1);
        a = oa; b = ob; carry_in = ocin; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got_lat = lat; got_sum = sum; got_err = err_detected;
        check("latency", lat, 1 + n);
        check("sum", sum, model_sum(oa, ob, ocin));
        check("err_detected", err_detected, (n != 0));
        model_cnt = (model_cnt + n > 32'hFFFF) ? 32'hFFFF : model_cnt + n;
`ifdef GEAR_ECU_STATS_EN
        check("err_cnt", err_cnt, model_cnt);
`endif
        held = sum;
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                a = ~oa; b = oa; in_valid = 1'b1;
            end
            @(negedge clk);
            check("stall_sum", sum, held);
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_out_valid", out_valid, 0);
        check("drain_in_ready", in_ready, 1);
    endtask

    logic [W-1:0] r_sum;
    int           r_lat;
    logic         r_err;

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_sum", sum, 0);
        check("rst_err_detected", err_detected, 0);
`ifdef GEAR_ECU_STATS_EN
        check("rst_err_cnt", err_cnt, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        run_op(16'h0005, 16'h000A, 1'b0, 0, 1'b0, r_sum, r_lat, r_err);
        check("t1_sum", r_sum, 16'h000F);
        check("t1_lat", r_lat, 1);
        check("t1_err", r_err, 0);

        run_op(16'h00FF, 16'h0001, 1'b0, 1, 1'b0, r_sum, r_lat, r_err);
        check("t2_sum", r_sum, 16'h0100);
        check("t2_lat", r_lat, 2);
        check("t2_err", r_err, 1);

        run_op(16'h0FFF, 16'h0001, 1'b0, 0, 1'b0, r_sum, r_lat, r_err);
        check("t3_sum", r_sum, 16'h1000);
        check("t3_lat", r_lat, 3);

        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, r_sum, r_lat, r_err);
        check("t4a_sum", r_sum, 16'h0000);
        run_op(16'h8000, 16'h8000, 1'b0, 0, 1'b0, r_sum, r_lat, r_err);
        check("t4b_sum", r_sum, 16'h0000);
        run_op(16'(-1234), 16'd1234, 1'b0, 0, 1'b0, r_sum, r_lat, r_err);
        check("t4c_sum", r_sum, 16'h0000);

        // Stall in DONE for five cycles while offering a new operand.
        run_op(16'h1234, 16'h4321, 1'b0, 5, 1'b1, r_sum, r_lat, r_err);
        check("t5_sum", r_sum, 16'h5555);
        repeat (2) begin
            @(negedge clk);
            check("t5_no_accept", out_valid, 0);
        end

        // Reset while correcting: the result must never appear.
        a = 16'h0FFF; b = 16'h0001; carry_in = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("t6_mid_out_valid", out_valid, 0);
        rst = 1'b1;
        #1;
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_in_ready", in_ready, 1);
        model_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_post_out_valid", out_valid, 0);
        check("t6_post_in_ready", in_ready, 1);
`ifdef GEAR_ECU_STATS_EN
        check("t6_err_cnt", err_cnt, 0);
`endif
        run_op(16'h0005, 16'h000A, 1'b0, 0, 1'b0, r_sum, r_lat, r_err);
        check("t6_sum", r_sum, 16'h000F);

        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            int unsigned  sel;
            ra  = W'($urandom);
            rb  = W'($urandom);
            rc  = 1'($urandom);
            sel = $urandom_range(0, 3);
            if (sel == 0) rb = ~ra;
            else if (sel == 1) rb = ~ra ^ W'(1 << $urandom_range(0, W - 1));
            run_op(ra, rb, rc, int'($urandom_range(0, 3)), 1'($urandom), r_sum, r_lat, r_err);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
